// File: rtl/sll_iter.sv
`default_nettype none
// ============================================================================
// Module      : sll_iter
// Description : Iterative logical shift-left, STEP bits per clock, with
//               start/valid handshake and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module sll_iter #(
  parameter int STEP = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_flush,
  input  logic [31:0] i_operand_a,
  input  logic [31:0] i_operand_b,
  output logic        o_ready,
  output logic        o_valid,
  output logic [31:0] o_sll_data,
  output logic        o_busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [4:0] c_STEP = 5'(STEP);

  state_t      r_state, w_state_nxt;
  logic [31:0] r_acc, w_acc_nxt;
  logic [31:0] r_data, w_data_nxt;
  logic [4:0]  r_cnt, w_cnt_nxt;
  logic [4:0]  w_k;
  logic        w_unused_b;

  assign w_unused_b = ^i_operand_b[31:5];

  // Final step may be shorter than STEP so the total never overshoots n.
  assign w_k = (r_cnt < c_STEP) ? r_cnt : c_STEP;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_data  <= w_data_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_data_nxt  = r_data;
    case (r_state)
      S_IDLE: begin
        if (i_start && !i_flush) begin
          w_acc_nxt   = i_operand_a;
          w_cnt_nxt   = i_operand_b[4:0];
          w_state_nxt = (i_operand_b[4:0] == 5'd0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (i_flush) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_acc_nxt = r_acc << w_k;
          w_cnt_nxt = r_cnt - w_k;
          if (r_cnt == w_k) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    // Result is captured on the edge that enters DONE so it lines up with o_valid.
    if (w_state_nxt == S_DONE) begin
      w_data_nxt = w_acc_nxt;
    end
  end

  assign o_ready    = (r_state == S_IDLE);
  assign o_busy     = ~o_ready;
  assign o_valid    = (r_state == S_DONE);
  assign o_sll_data = r_data;

endmodule
`default_nettype wire

// File: tb/tb_sll_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sll_iter
// Description : Scoreboard bench for sll_iter, one instance per legal STEP.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sll_iter;

  localparam int N_INST = 4;
  localparam int N_RAND = 1000;

  logic        clk;
  logic        rst_n   [N_INST];
  logic        start   [N_INST];
  logic        flush   [N_INST];
  logic [31:0] op_a    [N_INST];
  logic [31:0] op_b    [N_INST];
  logic        ready   [N_INST];
  logic        valid   [N_INST];
  logic        busy    [N_INST];
  logic [31:0] data    [N_INST];

  logic [31:0] exp_q   [N_INST][$];
  logic [31:0] model_last [N_INST];
  int          vcnt    [N_INST];
  int          exp_deliv [N_INST];
  int          total;
  int          bad;

  for (genvar g = 0; g < N_INST; g++) begin : g_dut
    sll_iter #(.STEP(1 << g)) u_dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n[g]),
      .i_start     (start[g]),
      .i_flush     (flush[g]),
      .i_operand_a (op_a[g]),
      .i_operand_b (op_b[g]),
      .o_ready     (ready[g]),
      .o_valid     (valid[g]),
      .o_sll_data  (data[g]),
      .o_busy      (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int j, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s step=%0d got=%h want=%h", name, 1 << j, act, want);
    end
  endtask

  // Monitor: every o_valid pops the next expected result for that instance.
  always @(negedge clk) begin
    for (int j = 0; j < N_INST; j++) begin
      if (valid[j] === 1'b1) begin
        vcnt[j]++;
        if (exp_q[j].size() == 0) begin
          chk("unexpected_valid", j, 32'd1, 32'd0);
        end else begin
          chk("result", j, data[j], exp_q[j].pop_front());
        end
      end
    end
  end

  function automatic int shifts_of(input int j, input logic [31:0] b);
    int n;
    n = int'(b[4:0]);
    return (n + (1 << j) - 1) / (1 << j);
  endfunction

  // flush_at: -1 for none, else the busy-cycle index (1-based) on which flush is raised.
  task automatic do_op(input int j, input logic [31:0] a, input logic [31:0] b, input int flush_at);
    int          sh, nbusy, nval, guard;
    bit          deliver, done;
    logic [31:0] prev;
    sh      = shifts_of(j, b);
    deliver = (flush_at < 0) || (flush_at > sh);
    prev    = model_last[j];
    guard   = 0;
    while (ready[j] !== 1'b1 && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 64) chk("ready_timeout", j, 32'd0, 32'd1);
    start[j] = 1'b1;
    op_a[j]  = a;
    op_b[j]  = b;
    @(posedge clk);
    if (deliver) begin
      exp_q[j].push_back(a << b[4:0]);
      model_last[j] = a << b[4:0];
      exp_deliv[j]++;
    end
    nbusy = 0;
    nval  = 0;
    done  = 1'b0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (ready[j] === 1'b1) begin
        done = 1'b1;
        break;
      end
      nbusy++;
      if (valid[j] === 1'b1) begin
        nval++;
        start[j] = 1'b0;
      end
      if (nbusy == flush_at) begin
        flush[j] = 1'b1;
        start[j] = 1'b0;
      end
    end
    flush[j] = 1'b0;
    start[j] = 1'b0;
    if (!done) chk("busy_timeout", j, 32'd0, 32'd1);
    chk("busy_cycles", j, 32'(nbusy), deliver ? 32'(sh + 1) : 32'(flush_at));
    chk("valid_pulses", j, 32'(nval), deliver ? 32'd1 : 32'd0);
    chk("busy_vs_ready", j, {31'd0, busy[j]}, {31'd0, ~ready[j]});
    if (!deliver) chk("flush_hold", j, data[j], prev);
  endtask

  initial begin
    logic [31:0] ra, rb;
    int          fa;
    total = 0;
    bad   = 0;
    for (int j = 0; j < N_INST; j++) begin
      rst_n[j] = 1'b0;
      start[j] = 1'b0;
      flush[j] = 1'b0;
      op_a[j]  = '0;
      op_b[j]  = '0;
      model_last[j] = '0;
      vcnt[j]  = 0;
      exp_deliv[j] = 0;
    end
    repeat (3) @(negedge clk);
    for (int j = 0; j < N_INST; j++) begin
      chk("rst_ready", j, {31'd0, ready[j]}, 32'd1);
      chk("rst_valid", j, {31'd0, valid[j]}, 32'd0);
      chk("rst_busy", j, {31'd0, busy[j]}, 32'd0);
      chk("rst_data", j, data[j], 32'd0);
      rst_n[j] = 1'b1;
    end
    @(negedge clk);

    for (int j = 0; j < N_INST; j++) begin
      do_op(j, 32'h0000_0001, 32'd31, -1);
      do_op(j, 32'hDEAD_BEEF, 32'd0, -1);
      do_op(j, 32'h1234_5678, 32'hFFFF_FFE4, -1);
      do_op(j, 32'hFFFF_FFFF, 32'd7, -1);
      do_op(j, 32'hA5A5_0F0F, 32'd10, 3);
      do_op(j, 32'h0BAD_F00D, 32'd12, shifts_of(j, 32'd12) + 1);

      // Start together with flush in IDLE must be dropped.
      start[j] = 1'b1;
      flush[j] = 1'b1;
      op_a[j]  = 32'hFFFF_0000;
      op_b[j]  = 32'd3;
      @(negedge clk);
      start[j] = 1'b0;
      flush[j] = 1'b0;
      chk("start_flush_ready", j, {31'd0, ready[j]}, 32'd1);
      chk("start_flush_data", j, data[j], model_last[j]);

      // Asynchronous reset in the middle of SHIFT.
      start[j] = 1'b1;
      op_a[j]  = 32'h1357_9BDF;
      op_b[j]  = 32'd20;
      @(negedge clk);
      start[j] = 1'b0;
      @(negedge clk);
      #2;
      rst_n[j] = 1'b0;
      #1;
      chk("async_rst_ready", j, {31'd0, ready[j]}, 32'd1);
      chk("async_rst_busy", j, {31'd0, busy[j]}, 32'd0);
      chk("async_rst_valid", j, {31'd0, valid[j]}, 32'd0);
      chk("async_rst_data", j, data[j], 32'd0);
      model_last[j] = '0;
      @(negedge clk);
      rst_n[j] = 1'b1;
      @(negedge clk);
      do_op(j, 32'h8765_4321, 32'd9, -1);

      for (int i = 0; i < N_RAND; i++) begin
        ra = $urandom;
        rb = $urandom;
        fa = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, shifts_of(j, rb) + 1)) : -1;
        do_op(j, ra, rb, fa);
      end
    end

    repeat (5) @(negedge clk);
    for (int j = 0; j < N_INST; j++) begin
      chk("valid_count", j, 32'(vcnt[j]), 32'(exp_deliv[j]));
      chk("queue_empty", j, 32'(exp_q[j].size()), 32'd0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
